// File: rtl/vtc_pkg.sv
// Shared timing constants, FSM state type and helpers for the video timing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package vtc_pkg;

  // 640x480 @ 60 Hz timing (25.175 MHz pixel clock class).
  localparam int VTC_H_ACTIVE = 640;
  localparam int VTC_H_FP     = 16;
  localparam int VTC_H_SYNC   = 96;
  localparam int VTC_H_BP     = 48;
  localparam int VTC_V_ACTIVE = 480;
  localparam int VTC_V_FP     = 10;
  localparam int VTC_V_SYNC   = 2;
  localparam int VTC_V_BP     = 33;
  localparam int VTC_CNT_W    = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } vtc_state_t;

  function automatic int vtc_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vtc_wrap_cnt.sv
// Modulo-MODULO wrap counter with synchronous clear, count enable and terminal-count flag.
// Latency: q updates one clock after en/clr; nxt and tc are combinational views of q.
// Backpressure: none; en simply holds the count.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset (q -> 0)
//   clr        : synchronous clear to 0, wins over en
//   en         : advance by one, wrapping MODULO-1 -> 0
//   q          : registered count
//   nxt        : value q takes on the next edge (lets the parent register aligned decodes)
//   tc         : q == MODULO-1
module vtc_wrap_cnt #(
  parameter int CNT_W  = 10,
  parameter int MODULO = 800
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] nxt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(MODULO - 1);

  assign tc = (q == LAST);

  always_comb begin
    nxt = q;
    if (clr) begin
      nxt = '0;
    end else if (en) begin
      nxt = tc ? '0 : q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/vtc_gen.sv
// Video timing generator: pixel/line counters plus hsync, vsync, active, sof, eol and busy flags.
// Latency: all outputs registered and aligned to the (X,Y) shown; RUN starts one clock after i_en=1.
// Backpressure: none; dropping i_en only stops the raster at a frame boundary.
//
// Ports:
//   i_clk, i_rstn          : clock and asynchronous active-low reset (forces idle outputs)
//   i_en                   : run request, sampled every clock
//   o_hsync, o_vsync       : syncs at HS_POL / VS_POL when asserted
//   o_active               : visible pixel
//   o_sof, o_eol           : start of frame, last visible pixel of a visible line
//   o_busy                 : FSM in RUN
//   o_counterX, o_counterY : current pixel and line
module vtc_gen
  import vtc_pkg::*;
#(
  parameter int H_ACTIVE = VTC_H_ACTIVE,
  parameter int H_FP     = VTC_H_FP,
  parameter int H_SYNC   = VTC_H_SYNC,
  parameter int H_BP     = VTC_H_BP,
  parameter int V_ACTIVE = VTC_V_ACTIVE,
  parameter int V_FP     = VTC_V_FP,
  parameter int V_SYNC   = VTC_V_SYNC,
  parameter int V_BP     = VTC_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CNT_W    = VTC_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_en,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_active,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_counterX,
  output logic [CNT_W-1:0] o_counterY
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Refuse to build with a degenerate timing or counters too narrow for the raster.
  if (H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_timing
    $error("vtc_gen: every timing parameter must be non-zero");
  end
  if ((longint'(1) << CNT_W) < longint'(vtc_max(H_TOTAL, V_TOTAL))) begin : g_bad_width
    $error("vtc_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  // Decode boundaries; every one is below its total, so it fits in CNT_W bits.
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_EOL_C  = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_SYN0_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYN1_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYN0_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYN1_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  vtc_state_t       state;
  vtc_state_t       state_nxt;
  logic             cnt_clr;
  logic             x_en;
  logic             y_en;
  logic [CNT_W-1:0] x_q;
  logic [CNT_W-1:0] x_nxt;
  logic [CNT_W-1:0] y_q;
  logic [CNT_W-1:0] y_nxt;
  logic             x_tc;
  logic             y_tc;
  logic             frame_end;
  logic             stop_pend;

  // Counters are parked at 0 in IDLE so the first RUN cycle is (0,0).
  // Leaving RUN happens only at (H_TOTAL-1, V_TOTAL-1), where both wrap
  // to 0 on their own, so no clear is needed on that edge.
  assign cnt_clr   = (state == ST_IDLE);
  assign x_en      = (state == ST_RUN);
  assign y_en      = x_en & x_tc;
  assign frame_end = x_tc & y_tc;

  // A stop request is pending whenever i_en is low; raising i_en again
  // withdraws it. It is only acted on at the frame-end edge, so the value
  // sampled on that edge decides and a partial frame is never produced.
  assign stop_pend = ~i_en;

  vtc_wrap_cnt #(
    .CNT_W  (CNT_W),
    .MODULO (H_TOTAL)
  ) u_x_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (cnt_clr),
    .en    (x_en),
    .q     (x_q),
    .nxt   (x_nxt),
    .tc    (x_tc)
  );

  vtc_wrap_cnt #(
    .CNT_W  (CNT_W),
    .MODULO (V_TOTAL)
  ) u_y_cnt (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .clr   (cnt_clr),
    .en    (y_en),
    .q     (y_q),
    .nxt   (y_nxt),
    .tc    (y_tc)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (i_en) state_nxt = ST_RUN;
      ST_RUN:  if (frame_end && stop_pend) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Flags are decoded from the next state and next counter values and then
  // registered, so each flag lands in the same cycle as the (X,Y) it describes.
  logic run_d;
  logic hs_d;
  logic vs_d;
  logic active_d;
  logic sof_d;
  logic eol_d;

  always_comb begin
    run_d    = (state_nxt == ST_RUN);
    hs_d     = ~HS_POL;
    vs_d     = ~VS_POL;
    active_d = 1'b0;
    sof_d    = 1'b0;
    eol_d    = 1'b0;
    if (run_d) begin
      hs_d     = (x_nxt >= H_SYN0_C && x_nxt < H_SYN1_C) ? HS_POL : ~HS_POL;
      vs_d     = (y_nxt >= V_SYN0_C && y_nxt < V_SYN1_C) ? VS_POL : ~VS_POL;
      active_d = (x_nxt < H_ACT_C) && (y_nxt < V_ACT_C);
      sof_d    = (x_nxt == '0) && (y_nxt == '0);
      eol_d    = (x_nxt == H_EOL_C) && (y_nxt < V_ACT_C);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_hsync  <= ~HS_POL;
      o_vsync  <= ~VS_POL;
      o_active <= 1'b0;
      o_sof    <= 1'b0;
      o_eol    <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      o_hsync  <= hs_d;
      o_vsync  <= vs_d;
      o_active <= active_d;
      o_sof    <= sof_d;
      o_eol    <= eol_d;
      o_busy   <= run_d;
    end
  end

  assign o_counterX = x_q;
  assign o_counterY = y_q;

endmodule

// File: tb/tb_vtc_gen.sv
// Bench for vtc_gen: three instances (default 640x480, default-H/short-V, tiny 14x7 positive-sync).
// Latency: a frame-position model is compared against every instance on every falling edge.
// Backpressure: n/a; directed i_en/i_rstn sequences with hand-computed literal checks.
module tb_vtc_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        sof;
    logic        eol;
    logic        busy;
    logic [15:0] x;
    logic [15:0] y;
  } obs_t;

  // Instance 0: defaults. 1: default H, V 4/1/2/1. 2: H 8/2/2/2, V 4/1/1/1, positive syncs.
  localparam int HA [3] = '{640, 640, 8};
  localparam int HF [3] = '{16, 16, 2};
  localparam int HS [3] = '{96, 96, 2};
  localparam int HB [3] = '{48, 48, 2};
  localparam int VA [3] = '{480, 4, 4};
  localparam int VF [3] = '{10, 1, 1};
  localparam int VS [3] = '{2, 2, 1};
  localparam int VB [3] = '{33, 1, 1};
  localparam int HP [3] = '{0, 0, 1};
  localparam int VP [3] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic [2:0] rstn;
  logic [2:0] en;
  logic [2:0] hs, vs, act, sof, eol, busy;
  logic [9:0] cx_d, cy_d, cx_m, cy_m;
  logic [3:0] cx_s, cy_s;
  bit         chk_on = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  vtc_gen u_def (
    .i_clk(clk), .i_rstn(rstn[0]), .i_en(en[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_active(act[0]), .o_sof(sof[0]),
    .o_eol(eol[0]), .o_busy(busy[0]), .o_counterX(cx_d), .o_counterY(cy_d)
  );

  vtc_gen #(
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_mid (
    .i_clk(clk), .i_rstn(rstn[1]), .i_en(en[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_active(act[1]), .o_sof(sof[1]),
    .o_eol(eol[1]), .o_busy(busy[1]), .o_counterX(cx_m), .o_counterY(cy_m)
  );

  vtc_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(4)
  ) u_sml (
    .i_clk(clk), .i_rstn(rstn[2]), .i_en(en[2]),
    .o_hsync(hs[2]), .o_vsync(vs[2]), .o_active(act[2]), .o_sof(sof[2]),
    .o_eol(eol[2]), .o_busy(busy[2]), .o_counterX(cx_s), .o_counterY(cy_s)
  );

  // Reference: each instance is just "running or not" plus a linear position
  // inside the frame; a frame is only left or re-entered at its last position.
  for (genvar g = 0; g < 3; g++) begin : g_model
    localparam int FRAME = (HA[g] + HF[g] + HS[g] + HB[g]) * (VA[g] + VF[g] + VS[g] + VB[g]);
    bit run = 1'b0;
    int p = 0;
    always @(posedge clk or negedge rstn[g]) begin
      if (!rstn[g]) begin
        run <= 1'b0;
        p   <= 0;
      end else if (!run) begin
        if (en[g]) begin
          run <= 1'b1;
          p   <= 0;
        end
      end else if (p == FRAME - 1) begin
        p <= 0;
        if (!en[g]) run <= 1'b0;
      end else begin
        p <= p + 1;
      end
    end
  end

  function automatic obs_t model_out(input int g, input bit run, input int p);
    obs_t o;
    int   ht, x, y;
    bit   hp, vp;
    hp = (HP[g] != 0);
    vp = (VP[g] != 0);
    o = '0;
    o.hs = !hp;
    o.vs = !vp;
    if (run) begin
      ht     = HA[g] + HF[g] + HS[g] + HB[g];
      x      = p % ht;
      y      = p / ht;
      o.hs   = (x >= HA[g] + HF[g] && x < HA[g] + HF[g] + HS[g]) ? hp : !hp;
      o.vs   = (y >= VA[g] + VF[g] && y < VA[g] + VF[g] + VS[g]) ? vp : !vp;
      o.act  = (x < HA[g]) && (y < VA[g]);
      o.sof  = (p == 0);
      o.eol  = (x == HA[g] - 1) && (y < VA[g]);
      o.busy = 1'b1;
      o.x    = 16'(x);
      o.y    = 16'(y);
    end
    return o;
  endfunction

  function automatic obs_t get_obs(input int i);
    obs_t o;
    o = '0;
    o.hs   = hs[i];
    o.vs   = vs[i];
    o.act  = act[i];
    o.sof  = sof[i];
    o.eol  = eol[i];
    o.busy = busy[i];
    case (i)
      0:       begin o.x = 16'(cx_d); o.y = 16'(cy_d); end
      1:       begin o.x = 16'(cx_m); o.y = 16'(cy_m); end
      default: begin o.x = 16'(cx_s); o.y = 16'(cy_s); end
    endcase
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t a, input obs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s @%0t dut=%h model=%h", nm, $time, a, e);
    end
  endtask

  task automatic chk(input string nm, input int a, input int e);
    n_tests++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s @%0t got %0d want %0d", nm, $time, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("model_def", get_obs(0), model_out(0, g_model[0].run, g_model[0].p));
      cmp("model_mid", get_obs(1), model_out(1, g_model[1].run, g_model[1].p));
      cmp("model_sml", get_obs(2), model_out(2, g_model[2].run, g_model[2].p));
    end
  end

  task automatic wait_pos(input int i, input int x, input int y, input int budget, input string nm);
    obs_t o;
    int   n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      o = get_obs(i);
    end while (!(o.x == 16'(x) && o.y == 16'(y) && o.busy) && n < budget);
    chk(nm, int'(o.x == 16'(x) && o.y == 16'(y) && o.busy), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   n, a, b, c, d, f1, f2;
    rstn = 3'b111;
    en   = 3'b000;
    #1 rstn = 3'b000;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    #2 rstn = 3'b111;
    repeat (4) @(negedge clk);

    // Idle after reset release with i_en low.
    o = get_obs(0);
    chk("idle_busy", o.busy, 0);
    chk("idle_x", o.x, 0);
    chk("idle_hs", o.hs, 1);
    chk("idle_vs", o.vs, 1);
    o = get_obs(2);
    chk("idle_sml_hs", o.hs, 0);

    // First RUN cycle at defaults.
    en[0] = 1'b1;
    @(negedge clk);
    o = get_obs(0);
    chk("first_sof", o.sof, 1);
    chk("first_x", o.x, 0);
    chk("first_y", o.y, 0);
    chk("first_act", o.act, 1);
    chk("first_hs", o.hs, 1);
    chk("first_vs", o.vs, 1);

    // One full line 0 at defaults.
    a = 0; b = 0; c = 0; d = -1; f1 = -1; f2 = -1;
    for (int i = 0; i < 800; i++) begin
      o = get_obs(0);
      if (!o.hs) begin
        a++;
        if (f1 < 0) f1 = o.x;
        f2 = o.x;
      end
      if (o.act) b++;
      if (o.eol) begin c++; d = o.x; end
      if (i < 799) @(negedge clk);
    end
    chk("line_hs_low", a, 96);
    chk("line_hs_first", f1, 656);
    chk("line_hs_last", f2, 751);
    chk("line_act", b, 640);
    chk("line_eol_n", c, 1);
    chk("line_eol_x", d, 639);
    chk("line_end_x", o.x, 799);
    chk("line_end_y", o.y, 0);
    @(negedge clk);
    o = get_obs(0);
    chk("wrap_x", o.x, 0);
    chk("wrap_y", o.y, 1);

    // Asynchronous reset mid-frame.
    wait_pos(0, 300, 5, 8000, "def_reach_300_5");
    #2 rstn[0] = 1'b0;
    #1 o = get_obs(0);
    chk("arst_busy", o.busy, 0);
    chk("arst_x", o.x, 0);
    chk("arst_y", o.y, 0);
    chk("arst_act", o.act, 0);
    chk("arst_hs", o.hs, 1);
    chk("arst_vs", o.vs, 1);
    en[0] = 1'b0;
    @(negedge clk);
    #2 rstn[0] = 1'b1;
    repeat (20) @(negedge clk);
    o = get_obs(0);
    chk("post_rst_idle", o.busy, 0);

    // Short-V instance: one frame of statistics.
    en[1] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; o = get_obs(1); end while (!o.sof && n < 100);
    chk("mid_start_sof", o.sof, 1);
    n = 0; a = 0; b = 0; f1 = -1; f2 = -1;
    do begin
      if (!o.vs) begin
        a++;
        if (f1 < 0) f1 = o.y;
        f2 = o.y;
      end
      if (o.act) b++;
      @(negedge clk);
      n++;
      o = get_obs(1);
    end while (!o.sof && n < 20000);
    chk("mid_sof_period", n, 6400);
    chk("mid_vs_low", a, 1600);
    chk("mid_vs_first", f1, 5);
    chk("mid_vs_last", f2, 6);
    chk("mid_act", b, 2560);

    // Stop request mid-frame completes the frame.
    wait_pos(1, 0, 2, 8000, "mid_reach_y2");
    en[1] = 1'b0;
    n = 0; a = -1; b = -1;
    o = get_obs(1);
    while (o.busy && n < 8000) begin
      a = o.x;
      b = o.y;
      @(negedge clk);
      n++;
      o = get_obs(1);
    end
    chk("stop_last_x", a, 799);
    chk("stop_last_y", b, 7);
    chk("stop_cycles", n, 4800);
    chk("stop_busy", o.busy, 0);
    chk("stop_x", o.x, 0);
    chk("stop_y", o.y, 0);

    // Stop withdrawn before frame end: next frame follows with no gap.
    en[1] = 1'b1;
    wait_pos(1, 0, 2, 8000, "mid2_reach_y2");
    en[1] = 1'b0;
    wait_pos(1, 0, 5, 8000, "mid2_reach_y5");
    en[1] = 1'b1;
    a = 0; c = 0;
    repeat (5000) begin
      @(negedge clk);
      o = get_obs(1);
      if (!o.busy) a++;
      if (o.sof) c++;
    end
    chk("resume_busy_gap", a, 0);
    chk("resume_sof_n", c, 1);
    en[1] = 1'b0;

    // Tiny positive-polarity instance.
    en[2] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; o = get_obs(2); end while (!o.sof && n < 20);
    chk("sml_start_sof", o.sof, 1);
    n = 0; a = 0; b = 0; c = 0; d = 0;
    do begin
      if (o.hs) a++;
      if (o.vs) b++;
      if (o.act) c++;
      if (o.eol) d++;
      @(negedge clk);
      n++;
      o = get_obs(2);
    end while (!o.sof && n < 500);
    chk("sml_sof_period", n, 98);
    chk("sml_hs_high", a, 14);
    chk("sml_vs_high", b, 14);
    chk("sml_act", c, 32);
    chk("sml_eol", d, 4);

    // i_en low exactly on the frame-end cycle stops.
    wait_pos(2, 13, 6, 200, "sml_reach_end");
    en[2] = 1'b0;
    @(negedge clk);
    o = get_obs(2);
    chk("end_stop_busy", o.busy, 0);
    chk("end_stop_x", o.x, 0);
    chk("end_stop_sof", o.sof, 0);

    // i_en back high on the frame-end cycle continues seamlessly.
    en[2] = 1'b1;
    wait_pos(2, 12, 6, 200, "sml_reach_12_6");
    en[2] = 1'b0;
    @(negedge clk);
    en[2] = 1'b1;
    @(negedge clk);
    o = get_obs(2);
    chk("late_resume_busy", o.busy, 1);
    chk("late_resume_sof", o.sof, 1);

    // Asynchronous reset mid-frame on positive polarity.
    wait_pos(2, 5, 3, 200, "sml_reach_5_3");
    #2 rstn[2] = 1'b0;
    #1 o = get_obs(2);
    chk("sml_arst_hs", o.hs, 0);
    chk("sml_arst_vs", o.vs, 0);
    chk("sml_arst_busy", o.busy, 0);
    chk("sml_arst_x", o.x, 0);
    en[2] = 1'b0;
    @(negedge clk);
    #2 rstn[2] = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
